ahb2apb_bridge: RTL and testbench

//  AHB-Lite slave that converts single AHB transfers into APB3 transfers to up to NPSEL peripherals.

---
 rtl/ahb2apb_bridge.sv | 226 ++++++++++++++++++++++
 tb/tb_ahb2apb_bridge.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave that turns single AHB transfers into APB3 transfers to up to NPSEL peripherals.
// Define APB_PSLVERR_EN to forward pslverr_i and unmapped accesses as a two-cycle AHB ERROR.
module ahb2apb_bridge #(
  parameter int WIDTH    = 32,
  parameter int NPSEL    = 4,
  parameter int SLOT_LSB = 12
) (
  input  logic                   hclk_i,
  input  logic                   hreset_i,
  input  logic                   hsel_i,
  input  logic [WIDTH-1:0]       haddr_i,
  input  logic [1:0]             htrans_i,
  input  logic                   hwrite_i,
  input  logic [2:0]             hsize_i,
  input  logic [WIDTH-1:0]       hwdata_i,
  input  logic                   hready_i,
  output logic [WIDTH-1:0]       hrdata_o,
  output logic                   hreadyout_o,
  output logic [1:0]             hresp_o,
  output logic [WIDTH-1:0]       paddr_o,
  output logic [NPSEL-1:0]       psel_o,
  output logic                   penable_o,
  output logic                   pwrite_o,
  output logic [WIDTH-1:0]       pwdata_o,
  input  logic [NPSEL*WIDTH-1:0] prdata_i,
  input  logic [NPSEL-1:0]       pready_i,
  input  logic [NPSEL-1:0]       pslverr_i
);

  localparam int SLOT_W = (NPSEL > 1) ? $clog2(NPSEL) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_SETUP,
`ifdef APB_PSLVERR_EN
    S_ACCESS,
    S_ERR1,
    S_ERR2
`else
    S_ACCESS
`endif
  } state_e;

  state_e             state_q, state_d;
  logic               hreadyout_q, hreadyout_d;
  logic [WIDTH-1:0]   hrdata_q, hrdata_d;
  logic [WIDTH-1:0]   paddr_q, paddr_d;
  logic               pwrite_q, pwrite_d;
  logic [WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [NPSEL-1:0]   psel_q, psel_d;
  logic               penable_q, penable_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic               mapped_q, mapped_d;

  logic [WIDTH-1:0]   prdata_arr [NPSEL];
  logic [3:0]         slot_raw;
  logic               accept;
  logic               slot_ready;

  for (genvar n = 0; n < NPSEL; n++) begin : g_prdata
    assign prdata_arr[n] = prdata_i[n*WIDTH +: WIDTH];
  end

  assign slot_raw   = haddr_i[SLOT_LSB+3:SLOT_LSB];
  assign accept     = hsel_i & hready_i & htrans_i[1] & (state_q == S_IDLE);
  assign slot_ready = pready_i[slot_q];

`ifdef APB_PSLVERR_EN
  logic [1:0] hresp_q, hresp_d;
  logic       slot_err;
  logic       unused_sig;

  assign slot_err   = pslverr_i[slot_q];
  assign unused_sig = ^{hsize_i, htrans_i[0]};
  assign hresp_o    = hresp_q;
`else
  logic unused_sig;

  assign unused_sig = ^{hsize_i, htrans_i[0], pslverr_i};
  assign hresp_o    = 2'b00;
`endif

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge hclk_i or posedge hreset_i) begin
    if (hreset_i) begin
      state_q     <= S_IDLE;
      hreadyout_q <= 1'b1;
      hrdata_q    <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      slot_q      <= '0;
      mapped_q    <= 1'b0;
`ifdef APB_PSLVERR_EN
      hresp_q     <= 2'b00;
`endif
    end else begin
      state_q     <= state_d;
      hreadyout_q <= hreadyout_d;
      hrdata_q    <= hrdata_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      slot_q      <= slot_d;
      mapped_q    <= mapped_d;
`ifdef APB_PSLVERR_EN
      hresp_q     <= hresp_d;
`endif
    end
  end

  // NOTE: default assignment first so no path through the case leaves a variable unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_LATCH;
`ifdef APB_PSLVERR_EN
      S_LATCH:  state_d = mapped_q ? S_SETUP : S_ERR1;
`else
      S_LATCH:  state_d = mapped_q ? S_SETUP : S_IDLE;
`endif
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: begin
        if (slot_ready) begin
`ifdef APB_PSLVERR_EN
          state_d = slot_err ? S_ERR1 : S_IDLE;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef APB_PSLVERR_EN
      S_ERR1:   state_d = S_ERR2;
      S_ERR2:   state_d = S_IDLE;
`endif
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are computed for the state being entered, so they appear registered.
  always_comb begin
    hreadyout_d = hreadyout_q;
    hrdata_d    = hrdata_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    slot_d      = slot_q;
    mapped_d    = mapped_q;
`ifdef APB_PSLVERR_EN
    hresp_d     = hresp_q;
`endif
    case (state_q)
      S_IDLE: begin
        hreadyout_d = 1'b1;
        if (accept) begin
          hreadyout_d = 1'b0;
          paddr_d     = haddr_i;
          pwrite_d    = hwrite_i;
          slot_d      = slot_raw[SLOT_W-1:0];
          mapped_d    = ({1'b0, slot_raw} < 5'(NPSEL));
        end
      end
      S_LATCH: begin
        pwdata_d = hwdata_i;
        if (mapped_q) begin
          psel_d         = '0;
          psel_d[slot_q] = 1'b1;
          penable_d      = 1'b0;
        end else begin
`ifdef APB_PSLVERR_EN
          hresp_d = 2'b01;
`else
          hreadyout_d = 1'b1;
          if (!pwrite_q) hrdata_d = '0;
`endif
        end
      end
      S_SETUP: penable_d = 1'b1;
      S_ACCESS: begin
        if (slot_ready) begin
          psel_d    = '0;
          penable_d = 1'b0;
`ifdef APB_PSLVERR_EN
          if (slot_err) begin
            hresp_d = 2'b01;
          end else begin
            hreadyout_d = 1'b1;
            if (!pwrite_q) hrdata_d = prdata_arr[slot_q];
          end
`else
          hreadyout_d = 1'b1;
          if (!pwrite_q) hrdata_d = prdata_arr[slot_q];
`endif
        end
      end
`ifdef APB_PSLVERR_EN
      S_ERR1: hreadyout_d = 1'b1;
      S_ERR2: begin
        hreadyout_d = 1'b1;
        hresp_d     = 2'b00;
      end
`endif
      default: begin
        hreadyout_d = 1'b1;
        psel_d      = '0;
        penable_d   = 1'b0;
      end
    endcase
  end

  assign hreadyout_o = hreadyout_q;
  assign hrdata_o    = hrdata_q;
  assign paddr_o     = paddr_q;
  assign pwrite_o    = pwrite_q;
  assign pwdata_o    = pwdata_q;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Self-checking bench for ahb2apb_bridge: table of single transfers plus hand-written
// sequences for reset, back-to-back pipelining, ignored transfers and reset mid-access.
module tb_ahb2apb_bridge;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           hsel;
  logic [W-1:0]   haddr;
  logic [1:0]     htrans;
  logic           hwrite;
  logic [2:0]     hsize;
  logic [W-1:0]   hwdata;
  logic           hready;
  logic [W-1:0]   hrdata;
  logic           hreadyout;
  logic [1:0]     hresp;
  logic [W-1:0]   paddr;
  logic [N-1:0]   psel;
  logic           penable;
  logic           pwrite;
  logic [W-1:0]   pwdata;
  logic [N*W-1:0] prdata;
  logic [N-1:0]   pready;
  logic [N-1:0]   pslverr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ahb2apb_bridge #(.WIDTH(W), .NPSEL(N), .SLOT_LSB(12)) dut (
    .hclk_i(clk), .hreset_i(rst), .hsel_i(hsel), .haddr_i(haddr), .htrans_i(htrans),
    .hwrite_i(hwrite), .hsize_i(hsize), .hwdata_i(hwdata), .hready_i(hready),
    .hrdata_o(hrdata), .hreadyout_o(hreadyout), .hresp_o(hresp), .paddr_o(paddr),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .pwdata_o(pwdata),
    .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );

  typedef struct {
    logic [W-1:0] haddr;
    logic         hwrite;
    logic [W-1:0] wdata;
    logic [W-1:0] rdata;
    int           nwait;
    logic         err;
    logic [N-1:0] exp_psel;
    int           exp_waits;
    logic [W-1:0] exp_hrdata;
    logic [1:0]   exp_resp;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    hsel   = 1'b0;
    htrans = 2'b00;
    hready = 1'b1;
  endtask

  // One isolated transfer; the bench plays the APB slave and counts AHB wait states.
  task automatic run_vec(input vec_t v, input string tag);
    int waits = 0;
    int acc = 0;
    int err_cyc = 0;
    bit seen_setup = 1'b0;
    @(negedge clk);
    for (int n = 0; n < N; n++)
      prdata[n*W +: W] = (n == int'(v.haddr[15:12])) ? v.rdata : (32'hF0F0_0000 | n);
    pready  = ~v.exp_psel;
    pslverr = ~v.exp_psel | (v.err ? v.exp_psel : '0);
    hsel = 1'b1; haddr = v.haddr; htrans = 2'b10; hwrite = v.hwrite; hready = 1'b1;
    @(negedge clk);
    idle_bus();
    hwdata = v.wdata;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (hreadyout) break;
      waits++;
      if (hresp == 2'b01) err_cyc++;
      if (psel != '0) begin
        check({tag, " psel"}, 32'(psel), 32'(v.exp_psel));
        if (!penable) begin
          seen_setup = 1'b1;
          check({tag, " paddr"}, paddr, v.haddr);
          check({tag, " pwrite"}, 32'(pwrite), 32'(v.hwrite));
          if (v.hwrite) check({tag, " pwdata"}, pwdata, v.wdata);
        end else begin
          check({tag, " paddr_hold"}, paddr, v.haddr);
          pready = ~v.exp_psel | ((acc >= v.nwait) ? v.exp_psel : '0);
          acc++;
        end
      end
      @(negedge clk);
    end
    if (hresp == 2'b01) err_cyc++;
    check({tag, " waits"}, 32'(waits), 32'(v.exp_waits));
    check({tag, " hrdata"}, hrdata, v.exp_hrdata);
    check({tag, " hresp"}, 32'(hresp), 32'(v.exp_resp));
    check({tag, " err_cycles"}, 32'(err_cyc), (v.exp_resp == 2'b01) ? 32'd2 : 32'd0);
    check({tag, " psel_seen"}, 32'(seen_setup), 32'(v.exp_psel != '0));
    @(negedge clk);
    check({tag, " idle_rdy"}, 32'(hreadyout), 32'd1);
    check({tag, " idle_resp"}, 32'(hresp), 32'd0);
  endtask

  initial begin
    vec_t vr;
    int bad;
    // {haddr, hwrite, wdata, rdata, nwait, err, exp_psel, exp_waits, exp_hrdata, exp_resp}
    vecs[0] = '{32'h0000_1004, 1'b1, 32'hA5A5_0001, 32'h0, 0, 1'b0, 4'b0010, 3, 32'h7777_1234, 2'b00};
    vecs[1] = '{32'h0000_3000, 1'b0, 32'h0, 32'hDEAD_BEEF, 2, 1'b0, 4'b1000, 5, 32'hDEAD_BEEF, 2'b00};
    vecs[2] = '{32'h0000_0008, 1'b0, 32'h0, 32'h1234_5678, 0, 1'b0, 4'b0001, 3, 32'h1234_5678, 2'b00};
`ifdef APB_PSLVERR_EN
    vecs[3] = '{32'h0000_1010, 1'b0, 32'h0, 32'hCAFE_0001, 1, 1'b1, 4'b0010, 5, 32'h1234_5678, 2'b01};
    vecs[4] = '{32'h0000_5000, 1'b0, 32'h0, 32'h0, 0, 1'b0, 4'b0000, 2, 32'h1234_5678, 2'b01};
    vecs[5] = '{32'h0000_2FFC, 1'b1, 32'h0BAD_F00D, 32'h0, 3, 1'b0, 4'b0100, 6, 32'h1234_5678, 2'b00};
    vecs[6] = '{32'h0000_F000, 1'b1, 32'h1111_2222, 32'h0, 0, 1'b0, 4'b0000, 2, 32'h1234_5678, 2'b01};
`else
    vecs[3] = '{32'h0000_1010, 1'b0, 32'h0, 32'hCAFE_0001, 1, 1'b1, 4'b0010, 4, 32'hCAFE_0001, 2'b00};
    vecs[4] = '{32'h0000_5000, 1'b0, 32'h0, 32'h0, 0, 1'b0, 4'b0000, 1, 32'h0, 2'b00};
    vecs[5] = '{32'h0000_2FFC, 1'b1, 32'h0BAD_F00D, 32'h0, 3, 1'b0, 4'b0100, 6, 32'h0, 2'b00};
    vecs[6] = '{32'h0000_F000, 1'b1, 32'h1111_2222, 32'h0, 0, 1'b0, 4'b0000, 1, 32'h0, 2'b00};
`endif
    vecs[7] = '{32'h0000_2000, 1'b0, 32'h0, 32'h55AA_55AA, 1, 1'b0, 4'b0100, 4, 32'h55AA_55AA, 2'b00};
    vr      = '{32'h0000_2004, 1'b0, 32'h0, 32'h1357_9BDF, 0, 1'b0, 4'b0100, 3, 32'h1357_9BDF, 2'b00};

    rst = 1'b1; hsize = 3'b010; hwdata = '0; haddr = '0; hwrite = 1'b0;
    idle_bus();
    prdata = '0; pready = '1; pslverr = '0;
    repeat (3) @(negedge clk);
    check("rst hreadyout", 32'(hreadyout), 32'd1);
    check("rst hresp", 32'(hresp), 32'd0);
    check("rst hrdata", hrdata, 32'h0);
    check("rst psel", 32'(psel), 32'd0);
    check("rst penable", 32'(penable), 32'd0);
    check("rst paddr", paddr, 32'h0);
    check("rst pwrite", 32'(pwrite), 32'd0);
    check("rst pwdata", pwdata, 32'h0);
    rst = 1'b0;

    // Write then read, second address phase in the write's completion cycle.
    @(negedge clk);
    prdata[3*W +: W] = 32'h7777_1234;
    hsel = 1'b1; haddr = 32'h0000_1004; htrans = 2'b10; hwrite = 1'b1;
    @(negedge clk);
    check("b2b t1 hreadyout", 32'(hreadyout), 32'd0);
    idle_bus(); hwdata = 32'hA5A5_0001;
    @(negedge clk);
    check("b2b t2 psel", 32'(psel), 32'b0010);
    check("b2b t2 penable", 32'(penable), 32'd0);
    check("b2b t2 paddr", paddr, 32'h0000_1004);
    check("b2b t2 pwrite", 32'(pwrite), 32'd1);
    check("b2b t2 pwdata", pwdata, 32'hA5A5_0001);
    @(negedge clk);
    check("b2b t3 psel", 32'(psel), 32'b0010);
    check("b2b t3 penable", 32'(penable), 32'd1);
    check("b2b t3 hreadyout", 32'(hreadyout), 32'd0);
    @(negedge clk);
    check("b2b t4 hreadyout", 32'(hreadyout), 32'd1);
    check("b2b t4 psel", 32'(psel), 32'd0);
    check("b2b t4 penable", 32'(penable), 32'd0);
    hsel = 1'b1; haddr = 32'h0000_3000; htrans = 2'b10; hwrite = 1'b0;
    @(negedge clk);
    check("b2b t5 accepted", 32'(hreadyout), 32'd0);
    check("b2b t5 psel", 32'(psel), 32'd0);
    idle_bus();
    @(negedge clk);
    check("b2b t6 psel", 32'(psel), 32'b1000);
    check("b2b t6 paddr", paddr, 32'h0000_3000);
    check("b2b t6 pwrite", 32'(pwrite), 32'd0);
    @(negedge clk);
    check("b2b t7 penable", 32'(penable), 32'd1);
    @(negedge clk);
    check("b2b t8 hreadyout", 32'(hreadyout), 32'd1);
    check("b2b t8 hrdata", hrdata, 32'h7777_1234);
    check("b2b t8 hresp", 32'(hresp), 32'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // IDLE htrans, missing hsel and low hready_i must all be ignored.
    bad = 0;
    @(negedge clk);
    hsel = 1'b1; haddr = 32'h0000_1000; htrans = 2'b00; hwrite = 1'b1;
    @(negedge clk);
    if (psel != '0 || !hreadyout) bad++;
    hsel = 1'b0; htrans = 2'b10;
    @(negedge clk);
    if (psel != '0 || !hreadyout) bad++;
    hsel = 1'b1; hready = 1'b0;
    @(negedge clk);
    if (psel != '0 || !hreadyout) bad++;
    idle_bus();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (psel != '0 || !hreadyout) bad++;
    end
    check("ignored transfers", 32'(bad), 32'd0);

    // Reset while a slot-2 read is stuck in ACCESS.
    @(negedge clk);
    pready = 4'b1011;
    hsel = 1'b1; haddr = 32'h0000_2000; htrans = 2'b10; hwrite = 1'b0;
    @(negedge clk);
    idle_bus();
    for (int i = 0; i < 10 && !penable; i++) @(negedge clk);
    check("rstacc in access", 32'(penable), 32'd1);
    rst = 1'b1;
    #1;
    check("rstacc psel", 32'(psel), 32'd0);
    check("rstacc penable", 32'(penable), 32'd0);
    check("rstacc hreadyout", 32'(hreadyout), 32'd1);
    check("rstacc hrdata", hrdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(vr, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
